aesl_deadlock_persist_monitor: RTL and testbench
================================================

# aesl_deadlock_persist_monitor

Parametrised deadlock monitor for the HLS co-simulation bench, instantiated once per pipelined sub-module under the top-level monitor tree. It combines a masked set of AXI-stream block flags with sub-instance idle/block flags, requires the blocking condition to persist for a programmable number of cycles before declaring deadlock, and reports the source and index of the first blocking stream. A sticky flag holds the event until the bench clears it.

## Interface
Parameters:
- NUM_AXIS, 8: number of axis_block_sigs bits
- AXIS_MASK, 8'h30: per-bit enable; only masked-in stream bits contribute
- NUM_SUB, 5: number of sub-instances monitored
- THRESH, 16: consecutive raw-block cycles required to assert block (range 1..255)
- IDX_W, $clog2(NUM_AXIS): width of block_idx

Ports:
- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- axis_block_sigs  in  NUM_AXIS  per-stream blocked flags
- inst_idle_sigs  in  NUM_SUB  per-sub-instance idle flags
- inst_block_sigs  in  NUM_SUB  per-sub-instance blocked flags
- clear  in  1  synchronous clear of FSM, sticky, index and source
- block  out  1  deadlock currently declared
- block_sticky  out  1  deadlock declared since last clear/reset
- block_src  out  2  bit0 = stream cause, bit1 = sub-instance cause, captured at declaration
- block_idx  out  IDX_W  lowest masked stream index blocking at declaration (0 if bit0 of block_src is 0)
- block_cycles  out  32  cycles spent in BLOCKED (see Configuration)

## Operation
- axis_hit = |(axis_block_sigs & AXIS_MASK).
- sub_hit = (&(inst_idle_sigs | inst_block_sigs)) & (|inst_block_sigs): every sub-instance is idle or blocked, and at least one is blocked.
- raw = axis_hit | sub_hit.
- 8-bit run counter cnt, saturating at 255.
- FSM states: IDLE, COUNT, BLOCKED.
  - IDLE: raw=1 -> cnt<=1; go to BLOCKED if THRESH==1, otherwise COUNT. raw=0 -> stay, cnt<=0.
  - COUNT: raw=0 -> IDLE, cnt<=0. raw=1 -> cnt<=cnt+1; when cnt+1 == THRESH -> BLOCKED.
  - BLOCKED: raw=1 -> stay. raw=0 -> IDLE, cnt<=0.
- block = (state == BLOCKED), registered.
- On every transition into BLOCKED: block_sticky<=1; block_src<={sub_hit, axis_hit}; block_idx<= lowest set index of the masked vector. Re-entry after a drop recaptures these values.
- clear=1: state<=IDLE, cnt<=0, block_sticky<=0, block_src<=0, block_idx<=0. Clear takes priority over raw in the same cycle. raw is re-evaluated from the next cycle.
- Unmasked stream bits never affect any output.

## Timing
- Reset (reset_n=0, asynchronous): state IDLE, cnt 0, block 0, block_sticky 0, block_src 0, block_idx 0, block_cycles 0.
- Latency: with raw rising before edge k and held, block is 1 after edge k+THRESH-1. With THRESH=1, block follows raw by one register stage.
- Deassertion: raw falling before edge k gives block=0 after edge k. block_sticky is unaffected.
- A single-cycle raw=0 glitch during COUNT restarts the count from zero.
- cnt saturates and never wraps.
- reset_n assertion mid-COUNT or mid-BLOCKED clears all state immediately, independent of clock.

## Configuration
- DEADLOCK_MON_CYCLE_CNT_EN defined: block_cycles increments by 1 every cycle the FSM is in BLOCKED and saturates at 32'hFFFF_FFFF. It is zeroed by reset or clear and holds its value after leaving BLOCKED.
- DEADLOCK_MON_CYCLE_CNT_EN not defined: block_cycles is tied to 0 and no counter is synthesised.

## Test plan
- THRESH=4, axis_block_sigs=8'h20 held -> block=1 after the 4th edge; block_src=2'b01, block_idx=5, block_sticky=1.
- THRESH=4, axis_block_sigs=8'h01 (unmasked) held for 20 cycles -> block and block_sticky stay 0.
- THRESH=4, raw high for 3 cycles, low 1 cycle, high 4 cycles -> block first rises 4 edges after the second rise.
- inst_idle_sigs=5'b11100, inst_block_sigs=5'b00011, THRESH=1 -> block=1 next edge, block_src=2'b10. Drop inst_block_sigs to 0 -> block=0 next edge, block_sticky still 1.
- While BLOCKED, pulse clear together with raw=1 -> block=0 and block_sticky=0 next edge; block reasserts THRESH edges later.
- With DEADLOCK_MON_CYCLE_CNT_EN defined: hold BLOCKED for 10 cycles, then assert reset_n=0 mid-cycle -> block_cycles reads 10 before the reset, then all outputs are 0 immediately on reset.

Source files
------------

// File: rtl/aesl_deadlock_persist_monitor.sv
// Per-sub-module deadlock monitor: declares deadlock once the masked stream/sub-instance blocking
// condition persists for THRESH cycles. Optional block_cycles counter under DEADLOCK_MON_CYCLE_CNT_EN.
module aesl_deadlock_persist_monitor #(
    parameter int unsigned                NUM_AXIS  = 8,
    parameter logic [NUM_AXIS-1:0]        AXIS_MASK = NUM_AXIS'(8'h30),
    parameter int unsigned                NUM_SUB   = 5,
    parameter int unsigned                THRESH    = 16,
    parameter int unsigned                IDX_W     = $clog2(NUM_AXIS)
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [NUM_AXIS-1:0] axis_block_sigs,
    input  logic [NUM_SUB-1:0]  inst_idle_sigs,
    input  logic [NUM_SUB-1:0]  inst_block_sigs,
    input  logic                clear,
    output logic                block,
    output logic                block_sticky,
    output logic [1:0]          block_src,
    output logic [IDX_W-1:0]    block_idx,
    output logic [31:0]         block_cycles
);

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned CMP_W   = CNT_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COUNT   = 2'd1,
        ST_BLOCKED = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [NUM_AXIS-1:0] masked_c;
    logic               axis_hit_c;
    logic               sub_hit_c;
    logic               raw_c;
    logic [IDX_W-1:0]   low_idx_c;
    logic [CNT_W-1:0]   cnt_inc_c;
    logic               hit_thresh_c;

    // Blocking condition and lowest masked stream index
    always_comb begin
        masked_c   = axis_block_sigs & AXIS_MASK;
        axis_hit_c = |masked_c;
        sub_hit_c  = (&(inst_idle_sigs | inst_block_sigs)) & (|inst_block_sigs);
        raw_c      = axis_hit_c | sub_hit_c;
        low_idx_c  = '0;
        for (int i = NUM_AXIS - 1; i >= 0; i--) begin
            if (masked_c[i]) low_idx_c = IDX_W'(i);
        end
    end

    // cnt is 0 in IDLE, so the same threshold compare covers THRESH==1 from IDLE
    always_comb begin
        cnt_inc_c    = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
        hit_thresh_c = (CMP_W'(cnt) + CMP_W'(1)) == CMP_W'(THRESH);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            block        <= 1'b0;
            block_sticky <= 1'b0;
            block_src    <= 2'b00;
            block_idx    <= '0;
        end else if (clear) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            block        <= 1'b0;
            block_sticky <= 1'b0;
            block_src    <= 2'b00;
            block_idx    <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_COUNT: begin
                    if (raw_c) begin
                        cnt <= cnt_inc_c;
                        if (hit_thresh_c) begin
                            state        <= ST_BLOCKED;
                            block        <= 1'b1;
                            block_sticky <= 1'b1;
                            block_src    <= {sub_hit_c, axis_hit_c};
                            block_idx    <= low_idx_c;
                        end else begin
                            state <= ST_COUNT;
                            block <= 1'b0;
                        end
                    end else begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        block <= 1'b0;
                    end
                end
                ST_BLOCKED: begin
                    if (raw_c) begin
                        cnt   <= cnt_inc_c;
                        block <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        block <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                    block <= 1'b0;
                end
            endcase
        end
    end

`ifdef DEADLOCK_MON_CYCLE_CNT_EN
    // Saturating residency counter; holds its value after leaving BLOCKED
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            block_cycles <= '0;
        end else if (clear) begin
            block_cycles <= '0;
        end else if ((state == ST_BLOCKED) && (block_cycles != 32'hFFFF_FFFF)) begin
            block_cycles <= block_cycles + 32'd1;
        end
    end
`else
    assign block_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_aesl_deadlock_persist_monitor.sv
// Randomized bench for aesl_deadlock_persist_monitor: two instances (THRESH 4 and 1) checked
// against a run-length reference model, plus the directed scenarios.
module tb_aesl_deadlock_persist_monitor;

    localparam int unsigned NUM_AXIS = 8;
    localparam logic [7:0]  MASK     = 8'h30;
    localparam int unsigned NUM_SUB  = 5;
    localparam int unsigned IDX_W    = 3;

`ifdef DEADLOCK_MON_CYCLE_CNT_EN
    localparam bit CYC_EN = 1'b1;
`else
    localparam bit CYC_EN = 1'b0;
`endif

    logic                clock = 1'b0;
    logic                reset_n;
    logic [NUM_AXIS-1:0] axis;
    logic [NUM_SUB-1:0]  idle;
    logic [NUM_SUB-1:0]  blk;
    logic                clear;

    logic             b4, s4, b1, s1;
    logic [1:0]       src4, src1;
    logic [IDX_W-1:0] idx4, idx1;
    logic [31:0]      cyc4, cyc1;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state, index 0 = THRESH 4, index 1 = THRESH 1
    int          th [2] = '{4, 1};
    int          run [2];
    bit          m_block [2];
    bit          m_sticky [2];
    logic [1:0]  m_src [2];
    int          m_idx [2];
    longint      m_cyc [2];

    aesl_deadlock_persist_monitor #(.NUM_AXIS(8), .AXIS_MASK(8'h30), .NUM_SUB(5), .THRESH(4)) dut4 (
        .clock(clock), .reset_n(reset_n), .axis_block_sigs(axis), .inst_idle_sigs(idle),
        .inst_block_sigs(blk), .clear(clear), .block(b4), .block_sticky(s4), .block_src(src4),
        .block_idx(idx4), .block_cycles(cyc4));

    aesl_deadlock_persist_monitor #(.NUM_AXIS(8), .AXIS_MASK(8'h30), .NUM_SUB(5), .THRESH(1)) dut1 (
        .clock(clock), .reset_n(reset_n), .axis_block_sigs(axis), .inst_idle_sigs(idle),
        .inst_block_sigs(blk), .clear(clear), .block(b1), .block_sticky(s1), .block_src(src1),
        .block_idx(idx1), .block_cycles(cyc1));

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            run[d] = 0; m_block[d] = 0; m_sticky[d] = 0; m_src[d] = 2'b00; m_idx[d] = 0; m_cyc[d] = 0;
        end
    endtask

    // Deadlock is declared once raw has held for th consecutive cycles since the last clear
    task automatic model_edge();
        bit   a_hit, s_hit, raw, nb;
        int   n_ok, n_blk, low;
        logic [7:0] m;
        m = axis & MASK;
        a_hit = (m != 0);
        n_ok = 0; n_blk = 0;
        for (int i = 0; i < NUM_SUB; i++) begin
            if (idle[i] || blk[i]) n_ok++;
            if (blk[i]) n_blk++;
        end
        s_hit = (n_ok == NUM_SUB) && (n_blk > 0);
        raw = a_hit || s_hit;
        low = 0;
        for (int i = NUM_AXIS - 1; i >= 0; i--) if (m[i]) low = i;
        for (int d = 0; d < 2; d++) begin
            if (clear) begin
                run[d] = 0; m_block[d] = 0; m_sticky[d] = 0; m_src[d] = 2'b00; m_idx[d] = 0; m_cyc[d] = 0;
            end else begin
                if (m_block[d] && m_cyc[d] < 64'hFFFF_FFFF) m_cyc[d]++;
                run[d] = raw ? run[d] + 1 : 0;
                nb = (run[d] >= th[d]);
                if (nb && !m_block[d]) begin
                    m_sticky[d] = 1; m_src[d] = {s_hit, a_hit}; m_idx[d] = low;
                end
                m_block[d] = nb;
            end
        end
    endtask

    task automatic check_all();
        check("t4_block",  32'(b4),   32'(m_block[0]));
        check("t4_sticky", 32'(s4),   32'(m_sticky[0]));
        check("t4_src",    32'(src4), 32'(m_src[0]));
        check("t4_idx",    32'(idx4), 32'(m_idx[0]));
        check("t4_cycles", cyc4,      CYC_EN ? 32'(m_cyc[0]) : 32'd0);
        check("t1_block",  32'(b1),   32'(m_block[1]));
        check("t1_sticky", 32'(s1),   32'(m_sticky[1]));
        check("t1_src",    32'(src1), 32'(m_src[1]));
        check("t1_idx",    32'(idx1), 32'(m_idx[1]));
        check("t1_cycles", cyc1,      CYC_EN ? 32'(m_cyc[1]) : 32'd0);
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic drive(input logic [7:0] a, input logic [4:0] i, input logic [4:0] b, input logic c);
        axis = a; idle = i; blk = b; clear = c;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_b4"}, 32'({b4, s4, src4, idx4}), 32'd0);
        check({tag, "_c4"}, cyc4, 32'd0);
        check({tag, "_b1"}, 32'({b1, s1, src1, idx1}), 32'd0);
        check({tag, "_c1"}, cyc1, 32'd0);
    endtask

    initial begin
        logic [4:0] r5;
        int mode, len;
        reset_n = 1'b0;
        drive(8'h00, 5'h00, 5'h00, 1'b0);
        model_reset();
        #3;
        check_reset_outputs("reset");
        @(negedge clock); @(negedge clock);
        reset_n = 1'b1;
        steps(2);

        // masked stream 5 held
        drive(8'h20, 5'h00, 5'h00, 1'b0);
        steps(3);
        check("tp1_pre", 32'(b4), 32'd0);
        step();
        check("tp1_block", 32'(b4), 32'd1);
        check("tp1_src", 32'(src4), 32'd1);
        check("tp1_idx", 32'(idx4), 32'd5);
        check("tp1_sticky", 32'(s4), 32'd1);
        drive(8'h00, 5'h00, 5'h00, 1'b0); step();
        drive(8'h00, 5'h00, 5'h00, 1'b1); step();

        // unmasked stream only
        drive(8'h01, 5'h00, 5'h00, 1'b0);
        steps(20);
        check("tp2_block", 32'(b4), 32'd0);
        check("tp2_sticky", 32'(s4), 32'd0);

        // glitch restarts count
        drive(8'h10, 5'h00, 5'h00, 1'b0); steps(3);
        drive(8'h00, 5'h00, 5'h00, 1'b0); step();
        drive(8'h10, 5'h00, 5'h00, 1'b0); steps(3);
        check("tp3_pre", 32'(b4), 32'd0);
        step();
        check("tp3_block", 32'(b4), 32'd1);
        drive(8'h00, 5'h00, 5'h00, 1'b1); step();

        // sub-instance cause on the THRESH=1 instance
        drive(8'h00, 5'b11100, 5'b00011, 1'b0); step();
        check("tp4_block", 32'(b1), 32'd1);
        check("tp4_src", 32'(src1), 32'd2);
        drive(8'h00, 5'b11100, 5'b00000, 1'b0); step();
        check("tp4_drop", 32'(b1), 32'd0);
        check("tp4_sticky", 32'(s1), 32'd1);

        // clear with raw held while blocked
        drive(8'h20, 5'h00, 5'h00, 1'b0); steps(5);
        check("tp5_pre", 32'(b4), 32'd1);
        drive(8'h20, 5'h00, 5'h00, 1'b1); step();
        check("tp5_clr_block", 32'(b4), 32'd0);
        check("tp5_clr_sticky", 32'(s4), 32'd0);
        drive(8'h20, 5'h00, 5'h00, 1'b0); steps(3);
        check("tp5_wait", 32'(b4), 32'd0);
        step();
        check("tp5_reassert", 32'(b4), 32'd1);

        // random segments
        for (int seg = 0; seg < 300; seg++) begin
            mode = $urandom_range(0, 5);
            len  = $urandom_range(1, 10);
            for (int k = 0; k < len; k++) begin
                case (mode)
                    0: drive(8'h00, 5'h00, 5'h00, 1'b0);
                    1: drive(8'($urandom) | (8'h10 << $urandom_range(0, 1)), 5'($urandom), 5'($urandom), 1'b0);
                    2: drive(8'($urandom) & ~MASK, 5'h00, 5'h00, 1'b0);
                    3: begin
                        r5 = 5'($urandom) | 5'(1 << $urandom_range(0, 4));
                        drive(8'($urandom) & ~MASK, ~r5 | 5'($urandom), r5, 1'b0);
                    end
                    4: drive(8'h00, 5'($urandom), 5'($urandom), 1'b0);
                    default: drive(8'($urandom), 5'($urandom), 5'($urandom), 1'b0);
                endcase
                clear = ($urandom_range(0, 40) == 0);
                step();
            end
        end

        // residency count then asynchronous reset mid-cycle
        drive(8'h00, 5'h00, 5'h00, 1'b1); step();
        drive(8'h20, 5'h00, 5'h00, 1'b0); steps(4);
        check("tp6_block", 32'(b4), 32'd1);
        steps(10);
        check("tp6_cycles", cyc4, CYC_EN ? 32'd10 : 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("async_reset");
        @(negedge clock);
        reset_n = 1'b1;
        drive(8'h00, 5'h00, 5'h00, 1'b0);
        steps(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
